// File: rtl/phys_reg_free_list_pkg.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list_pkg
//   Shared constants and types for the physical-register free list.
//   PHY_REG_NUM / PHY_REG_SEL : physical register file size and tag width.
//   REG_NUM                   : architectural register count. Physical tags
//                               below REG_NUM hold the initial architectural
//                               mapping, so the free list starts at REG_NUM.
//   FL_NUM / FL_SEL           : free-list depth (power of two) and pointer
//                               width.
// ---------------------------------------------------------------------------
package phys_reg_free_list_pkg;

   localparam int PHY_REG_NUM = 64;
   localparam int PHY_REG_SEL = 6;
   localparam int REG_NUM     = 32;
   localparam int FL_NUM      = PHY_REG_NUM - REG_NUM;
   localparam int FL_SEL      = 5;

   typedef logic [PHY_REG_SEL-1:0] tag_t;

   // Tag held by free-list entry idx right after reset.
   function automatic tag_t reset_tag(input int idx);
      return tag_t'(REG_NUM + idx);
   endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//   Circular FIFO of free physical-register tags for a 2-wide rename stage.
//   Rename pops up to two tags from head; commit pushes up to two released
//   tags at tail; cptr trails head by the committed allocations so that a
//   misprediction can return every speculative tag in one cycle by pulling
//   head back to cptr.
//
// Ports
//   clk                           : clock, all state changes on rising edge
//   reset                         : asynchronous, active-high
//   alloc_req1 / alloc_req2       : rename slot needs a tag (req2 needs req1)
//   stall_DP                      : dispatch stalled, nothing is consumed
//   alloc_tag1 / alloc_tag2       : tags at head and head+1
//   allocatable                   : enough free tags for this request
//   release_valid1/2, release_tag1/2 : tags returned by commit
//   commit_has_dst1 / commit_has_dst2 : committed instr owned a renamed tag
//   prmiss                        : flush speculative allocations
//   free_count                    : number of free tags
//
// Allocation handshake: alloc_req1/alloc_req2 act as valid, allocatable acts
// as ready. A request is consumed on a rising edge only when allocatable is
// high, stall_DP is low and prmiss is low; alloc_tag1/2 are then the tags
// handed out. allocatable looks only at the registered count, so tags being
// released in the same cycle cannot satisfy the current request.
// ---------------------------------------------------------------------------
module phys_reg_free_list
   import phys_reg_free_list_pkg::*;
#(
   parameter int FL_NUM_P = FL_NUM,   // depth, power of two
   parameter int FL_SEL_P = FL_SEL    // log2(FL_NUM_P)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_req1,
   input  logic             alloc_req2,
   input  logic             stall_DP,
   output tag_t             alloc_tag1,
   output tag_t             alloc_tag2,
   output logic             allocatable,
   input  logic             release_valid1,
   input  logic             release_valid2,
   input  tag_t             release_tag1,
   input  tag_t             release_tag2,
   input  logic             commit_has_dst1,
   input  logic             commit_has_dst2,
   input  logic             prmiss,
   output logic [FL_SEL_P:0] free_count
);

   localparam int CW = FL_SEL_P + 1;

   typedef logic [FL_SEL_P-1:0] ptr_t;
   typedef logic [CW-1:0]       cnt_t;

   tag_t entry [FL_NUM_P];

   ptr_t head, tail, cptr;
   ptr_t head_p1, tail_p1;
   ptr_t head_next, tail_next, cptr_next;
   ptr_t cmtnum;
   ptr_t spec_num;
   cnt_t count, count_next;
   cnt_t reqnum, relnum;
   logic accepted;

   // Write ports: port 0 always writes at tail, port 1 at tail+1. When only
   // release_valid2 is set its tag takes port 0 so the list stays dense.
   logic wr0_en, wr1_en;
   tag_t wr0_data, wr1_data;

   // Pointers wrap through FL_SEL_P-bit modulo arithmetic.
   always_comb begin
      head_p1 = head + ptr_t'(1);
      tail_p1 = tail + ptr_t'(1);
   end

   // Read ports.
   always_comb begin
      alloc_tag1 = entry[head];
      alloc_tag2 = entry[head_p1];
   end

   always_comb begin
      reqnum = (alloc_req1 && alloc_req2) ? cnt_t'(2) :
               alloc_req1                 ? cnt_t'(1) : cnt_t'(0);
      relnum = cnt_t'(release_valid1) + cnt_t'(release_valid2);
      cmtnum = ptr_t'(commit_has_dst1) + ptr_t'(commit_has_dst2);
   end

   always_comb begin
      allocatable = (count >= reqnum);
      accepted    = ~prmiss && ~stall_DP && allocatable;
      free_count  = count;
   end

   always_comb begin
      wr0_en   = release_valid1 || release_valid2;
      wr0_data = release_valid1 ? release_tag1 : release_tag2;
      wr1_en   = release_valid1 && release_valid2;
      wr1_data = release_tag2;
   end

   // Next pointers and count. Releases and commits always proceed, even on
   // prmiss and stall cycles. On prmiss head snaps to the post-commit cptr;
   // everything between that point and the old head was speculative and is
   // returned to the free pool.
   always_comb begin
      tail_next  = tail + ptr_t'(relnum);
      cptr_next  = cptr + cmtnum;
      spec_num   = head - cptr_next;
      head_next  = head;
      count_next = count;
      if (prmiss) begin
         head_next  = cptr_next;
         count_next = count + relnum + cnt_t'(spec_num);
      end else begin
         if (accepted) begin
            head_next = head + ptr_t'(reqnum);
         end
         count_next = count + relnum - (accepted ? reqnum : cnt_t'(0));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FL_NUM_P; i++) begin
            entry[i] <= reset_tag(i);
         end
         head  <= '0;
         tail  <= '0;
         cptr  <= '0;
         count <= cnt_t'(FL_NUM_P);
      end else begin
         if (wr0_en) begin
            entry[tail] <= wr0_data;
         end
         if (wr1_en) begin
            entry[tail_p1] <= wr1_data;
         end
         head  <= head_next;
         tail  <= tail_next;
         cptr  <= cptr_next;
         count <= count_next;
      end
   end

   // More free tags than entries means a release was duplicated or a
   // prmiss recovery over-counted.
   count_in_range: assert property (
      @(posedge clk) disable iff (reset) count <= cnt_t'(FL_NUM_P))
      else $error("free-list count %0d exceeds depth %0d", count, FL_NUM_P);

endmodule

// File: tb/tb_phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_free_list
//   Directed bench for phys_reg_free_list. The driver applies one cycle of
//   inputs right after each rising edge and queues the outputs it expects to
//   see during that cycle; the monitor compares on the falling edge.
//   Expected record layout: {alloc_tag1, alloc_tag2, allocatable, free_count}.
// ---------------------------------------------------------------------------
module tb_phys_reg_free_list;
   import phys_reg_free_list_pkg::*;

   localparam int EW = 2 * PHY_REG_SEL + 1 + FL_SEL + 1;

   logic       clk;
   logic       reset;
   logic       alloc_req1, alloc_req2, stall_DP;
   tag_t       alloc_tag1, alloc_tag2;
   logic       allocatable;
   logic       release_valid1, release_valid2;
   tag_t       release_tag1, release_tag2;
   logic       commit_has_dst1, commit_has_dst2;
   logic       prmiss;
   logic [FL_SEL:0] free_count;

   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            checks;
   int            errors;

   phys_reg_free_list dut (
      .clk             (clk),
      .reset           (reset),
      .alloc_req1      (alloc_req1),
      .alloc_req2      (alloc_req2),
      .stall_DP        (stall_DP),
      .alloc_tag1      (alloc_tag1),
      .alloc_tag2      (alloc_tag2),
      .allocatable     (allocatable),
      .release_valid1  (release_valid1),
      .release_valid2  (release_valid2),
      .release_tag1    (release_tag1),
      .release_tag2    (release_tag2),
      .commit_has_dst1 (commit_has_dst1),
      .commit_has_dst2 (commit_has_dst2),
      .prmiss          (prmiss),
      .free_count      (free_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected to finish earlier");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      alloc_req1      = 1'b0;
      alloc_req2      = 1'b0;
      stall_DP        = 1'b0;
      release_valid1  = 1'b0;
      release_valid2  = 1'b0;
      release_tag1    = '0;
      release_tag2    = '0;
      commit_has_dst1 = 1'b0;
      commit_has_dst2 = 1'b0;
      prmiss          = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic req(input logic r1, input logic r2);
      alloc_req1 = r1;
      alloc_req2 = r2;
   endtask

   task automatic rel(input logic v1, input int t1, input logic v2, input int t2);
      release_valid1 = v1;
      release_tag1   = tag_t'(t1);
      release_valid2 = v2;
      release_tag2   = tag_t'(t2);
   endtask

   task automatic expect_out(input int t1, input int t2, input int a,
                             input int c, input string nm);
      exp_q.push_back({tag_t'(t1), tag_t'(t2), 1'(a), (FL_SEL+1)'(c)});
      name_q.push_back(nm);
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [EW-1:0] mon_exp;
   logic [EW-1:0] mon_act;
   string         mon_name;

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = {alloc_tag1, alloc_tag2, allocatable, free_count};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL %s: got tag1=%0d tag2=%0d alloc=%0d cnt=%0d, expected tag1=%0d tag2=%0d alloc=%0d cnt=%0d",
                     mon_name,
                     mon_act[EW-1 -: PHY_REG_SEL], mon_act[EW-1-PHY_REG_SEL -: PHY_REG_SEL],
                     mon_act[FL_SEL+1], mon_act[FL_SEL:0],
                     mon_exp[EW-1 -: PHY_REG_SEL], mon_exp[EW-1-PHY_REG_SEL -: PHY_REG_SEL],
                     mon_exp[FL_SEL+1], mon_exp[FL_SEL:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_inputs();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      expect_out(32, 33, 1, 32, "reset_state");
      @(negedge clk);
      #1 reset = 1'b0;

      // Two tags, then the next head.
      next_cycle(); req(1, 1); expect_out(32, 33, 1, 32, "alloc2_first");
      next_cycle();            expect_out(34, 35, 1, 30, "alloc2_next");

      // Drain the list with 15 more double allocations (16 total).
      for (int k = 0; k < 15; k++) begin
         next_cycle(); req(1, 1);
         expect_out(34 + 2*k, 35 + 2*k, 1, 30 - 2*k, "drain_alloc2");
      end
      // Empty: head back at 0, single request refused and not consumed.
      next_cycle(); req(1, 0); expect_out(32, 33, 0, 0, "empty_refuse_req1");
      next_cycle(); req(1, 0); expect_out(32, 33, 0, 0, "empty_refuse_hold");

      // Double release into an empty list.
      next_cycle(); rel(1, 5, 1, 7); expect_out(32, 33, 1, 0, "rel2_drive");
      next_cycle();                  expect_out(5, 7, 1, 2, "rel2_tags");

      // release_valid2 alone lands at the old tail (index 2).
      next_cycle(); rel(0, 0, 1, 9);  expect_out(5, 7, 1, 2, "rel2only_drive");
      next_cycle(); req(1, 0);        expect_out(5, 7, 1, 3, "rel2only_count");
      next_cycle(); rel(1, 11, 0, 0); expect_out(7, 9, 1, 2, "rel2only_old_tail");
      next_cycle(); req(1, 1);        expect_out(7, 9, 1, 3, "tail_step1_alloc");
      // Tag 11 sits at index 3, so tail moved by exactly one. Count 1 < 2.
      next_cycle(); req(1, 1);        expect_out(11, 36, 0, 1, "req2_refused_cnt1");
      next_cycle();                   expect_out(11, 36, 1, 1, "req2_refused_hold");

      // Fresh reset, then stall, 6 allocations, 2 commits, prmiss.
      next_cycle(); reset = 1'b1;     expect_out(32, 33, 1, 32, "reset_again");
      @(negedge clk);
      #1 reset = 1'b0;
      next_cycle(); req(1, 1); stall_DP = 1'b1; expect_out(32, 33, 1, 32, "stall_no_alloc");
      next_cycle(); req(1, 1); expect_out(32, 33, 1, 32, "pm_alloc_a");
      next_cycle(); req(1, 1); expect_out(34, 35, 1, 30, "pm_alloc_b");
      next_cycle(); req(1, 1); commit_has_dst1 = 1'b1; commit_has_dst2 = 1'b1;
      expect_out(36, 37, 1, 28, "pm_alloc_c_commit2");
      next_cycle(); req(1, 1); prmiss = 1'b1; expect_out(38, 39, 1, 26, "prmiss_drive");
      next_cycle();            expect_out(34, 35, 1, 30, "prmiss_restore");

      // Simultaneous 2-alloc / 2-release walking head to the wrap point.
      for (int k = 0; k < 14; k++) begin
         next_cycle(); req(1, 1); rel(1, 2*k, 1, 2*k + 1);
         expect_out(34 + 2*k, 35 + 2*k, 1, 30, "dual_alloc_rel");
      end
      next_cycle(); req(1, 1); rel(1, 50, 1, 51); expect_out(62, 63, 1, 30, "wrap_head30");
      next_cycle(); req(1, 1); rel(1, 52, 1, 53); expect_out(0, 1, 1, 30, "wrap_head0");
      next_cycle();                               expect_out(2, 3, 1, 30, "wrap_after");

      // Reset inside a cycle with pending traffic: outputs change at once.
      next_cycle(); req(1, 1); rel(1, 20, 1, 21);
      #1 reset = 1'b1;
      expect_out(32, 33, 1, 32, "async_reset_mid");
      @(negedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
      next_cycle(); expect_out(32, 33, 1, 32, "after_async_reset");

      // Let the monitor drain, then confirm nothing was left unchecked.
      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
